// File: rtl/io_pkg.sv
// Shared definitions for the IO bus sequencer: state encoding, counter widths
// and the strobe-length helper.
package io_pkg;

    localparam int unsigned CNT_W = 4;
    // One extra bit so STROBE_CYCLES + SLOW_EXTRA (up to 30) cannot overflow.
    localparam int unsigned LEN_W = CNT_W + 1;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold,
        StAck
    } state_t;

    function automatic logic [LEN_W-1:0] strobe_len(
        input logic [7:0]       addr,
        input logic [7:0]       slow_base,
        input logic [CNT_W-1:0] strobe,
        input logic [CNT_W-1:0] extra
    );
        strobe_len = {1'b0, strobe} + ((addr >= slow_base) ? {1'b0, extra} : '0);
    endfunction

endpackage

// File: rtl/io_wait_timer.sv
// Loadable down-counter; o_done is high while the count is zero, so loading
// N-1 makes o_done rise in the N-th cycle after the load edge.
module io_wait_timer
    import io_pkg::*;
#(
    parameter int unsigned WIDTH = LEN_W
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_done
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            count_q <= '0;
        end else if (i_load) begin
            count_q <= i_value;
        end else if (count_q != '0) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign o_done = (count_q == '0);

endmodule

// File: rtl/io_sequencer.sv
// Single-outstanding IO bus sequencer: turns a level request into a
// setup/strobe/hold peripheral cycle with an address-dependent strobe length.
module io_sequencer
    import io_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES  = 1,
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES   = 1,
    parameter logic [7:0]  SLOW_BASE     = 8'h80,
    parameter int unsigned SLOW_EXTRA    = 2
) (
    input  logic       i_clk,
    input  logic       i_resetn,
    input  logic       i_req,
    input  logic       i_write,
    input  logic [7:0] i_address,
    input  logic [7:0] i_wdata,
    output logic       o_ack,
    output logic [7:0] o_rdata,
    output logic       o_busy,
    output logic       o_ioSelect,
    output logic [7:0] o_ioAddress,
    output logic       o_ioNOE,
    output logic       o_ioNWE,
    output logic [7:0] o_bus,
    output logic       o_busDrive,
    input  logic [7:0] i_bus
);

    localparam logic [LEN_W-1:0] SETUP_LOAD = LEN_W'(SETUP_CYCLES) - LEN_W'(1);
    localparam logic [LEN_W-1:0] HOLD_LOAD  = LEN_W'(HOLD_CYCLES) - LEN_W'(1);

    state_t           state_q, state_d;
    logic             write_q;
    logic [7:0]       addr_q, wdata_q, rdata_q;
    logic             accept, capture;
    logic             tmr_load, tmr_done;
    logic [LEN_W-1:0] tmr_value;
    logic [LEN_W-1:0] strobe_load_in, strobe_load_q;

    assign strobe_load_in = strobe_len(i_address, SLOW_BASE, CNT_W'(STROBE_CYCLES),
                                       CNT_W'(SLOW_EXTRA)) - LEN_W'(1);
    assign strobe_load_q  = strobe_len(addr_q, SLOW_BASE, CNT_W'(STROBE_CYCLES),
                                       CNT_W'(SLOW_EXTRA)) - LEN_W'(1);

    io_wait_timer #(
        .WIDTH(LEN_W)
    ) u_timer (
        .i_clk   (i_clk),
        .i_resetn(i_resetn),
        .i_load  (tmr_load),
        .i_value (tmr_value),
        .o_done  (tmr_done)
    );

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        capture   = 1'b0;
        tmr_load  = 1'b0;
        tmr_value = '0;
        unique case (state_q)
            StIdle: begin
                if (i_req) begin
                    accept   = 1'b1;
                    tmr_load = 1'b1;
                    if (SETUP_CYCLES != 0) begin
                        state_d   = StSetup;
                        tmr_value = SETUP_LOAD;
                    end else begin
                        state_d   = StStrobe;
                        tmr_value = strobe_load_in;
                    end
                end
            end
            StSetup: begin
                if (tmr_done) begin
                    state_d   = StStrobe;
                    tmr_load  = 1'b1;
                    tmr_value = strobe_load_q;
                end
            end
            StStrobe: begin
                if (tmr_done) begin
                    capture = !write_q;
                    if (HOLD_CYCLES != 0) begin
                        state_d   = StHold;
                        tmr_load  = 1'b1;
                        tmr_value = HOLD_LOAD;
                    end else begin
                        state_d = StAck;
                    end
                end
            end
            StHold: begin
                if (tmr_done) begin
                    state_d = StAck;
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q <= StIdle;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                write_q <= i_write;
                addr_q  <= i_address;
                wdata_q <= i_wdata;
            end
            if (capture) begin
                rdata_q <= i_bus;
            end
        end
    end

    // Outputs decode straight from the async-reset state so reset drops strobes at once.
    logic active, strobing;
    assign active   = (state_q == StSetup) || (state_q == StStrobe) || (state_q == StHold);
    assign strobing = (state_q == StStrobe);

    assign o_busy      = (state_q != StIdle);
    assign o_ack       = (state_q == StAck);
    assign o_ioSelect  = active;
    assign o_ioAddress = addr_q;
    assign o_ioNOE     = !(strobing && !write_q);
    assign o_ioNWE     = !(strobing && write_q);
    assign o_busDrive  = active && write_q;
    assign o_bus       = wdata_q;
    assign o_rdata     = rdata_q;

endmodule

// File: tb/tb_io_sequencer.sv
// Bench for io_sequencer: a default instance and a no-setup/no-hold instance share
// stimulus; a transaction-timeline model is checked every cycle plus literal timelines.
module tb_io_sequencer;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic req = 1'b0, write = 1'b0;
    logic [7:0] address = 8'h00, wdata = 8'h00, bus_in = 8'h00;

    logic [1:0]      ack_w, busy_w, sel_w, noe_w, nwe_w, drv_w;
    logic [1:0][7:0] addr_w, bus_w, rdata_w;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    io_sequencer u_dut_a (
        .i_clk(clk), .i_resetn(resetn), .i_req(req), .i_write(write),
        .i_address(address), .i_wdata(wdata),
        .o_ack(ack_w[0]), .o_rdata(rdata_w[0]), .o_busy(busy_w[0]),
        .o_ioSelect(sel_w[0]), .o_ioAddress(addr_w[0]), .o_ioNOE(noe_w[0]),
        .o_ioNWE(nwe_w[0]), .o_bus(bus_w[0]), .o_busDrive(drv_w[0]), .i_bus(bus_in)
    );

    io_sequencer #(
        .SETUP_CYCLES(0), .HOLD_CYCLES(0)
    ) u_dut_b (
        .i_clk(clk), .i_resetn(resetn), .i_req(req), .i_write(write),
        .i_address(address), .i_wdata(wdata),
        .o_ack(ack_w[1]), .o_rdata(rdata_w[1]), .o_busy(busy_w[1]),
        .o_ioSelect(sel_w[1]), .o_ioAddress(addr_w[1]), .o_ioNOE(noe_w[1]),
        .o_ioNWE(nwe_w[1]), .o_bus(bus_w[1]), .o_busDrive(drv_w[1]), .i_bus(bus_in)
    );

    task automatic check(input int inst, input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL dut%0d %s: got %h, expected %h at %0t", inst, name, act, exp, $time);
        end
    endtask

    // Transaction model: cycle k (1-based after the acceptance edge) places the
    // transaction in setup [1..S], strobe [S+1..S+L], hold [..S+L+H], ack S+L+H+1.
    int         m_s[2] = '{1, 0};
    int         m_h[2] = '{1, 0};
    bit         m_act[2] = '{0, 0};
    int         m_k[2] = '{0, 0};
    int         m_len[2] = '{0, 0};
    logic       m_wr[2] = '{0, 0};
    logic [7:0] m_addr[2] = '{0, 0};
    logic [7:0] m_wd[2] = '{0, 0};
    logic [7:0] m_rd[2] = '{0, 0};

    always @(posedge clk or negedge resetn) begin
        for (int i = 0; i < 2; i++) begin
            if (!resetn) begin
                m_act[i] = 0; m_k[i] = 0; m_wr[i] = 0;
                m_addr[i] = 0; m_wd[i] = 0; m_rd[i] = 0;
            end else if (!m_act[i]) begin
                if (req) begin
                    m_act[i] = 1; m_k[i] = 1; m_wr[i] = write;
                    m_addr[i] = address; m_wd[i] = wdata;
                    m_len[i] = (address >= 8'h80) ? 4 : 2;
                end
            end else begin
                if (!m_wr[i] && m_k[i] == m_s[i] + m_len[i]) m_rd[i] = bus_in;
                if (m_k[i] == m_s[i] + m_len[i] + m_h[i] + 1) m_act[i] = 0;
                else m_k[i]++;
            end
        end
    end

    always @(negedge clk) begin
        bit e_sel, e_stb, e_ack;
        for (int i = 0; i < 2; i++) begin
            e_sel = m_act[i] && m_k[i] <= m_s[i] + m_len[i] + m_h[i];
            e_stb = m_act[i] && m_k[i] > m_s[i] && m_k[i] <= m_s[i] + m_len[i];
            e_ack = m_act[i] && m_k[i] == m_s[i] + m_len[i] + m_h[i] + 1;
            check(i, "busy", 16'(busy_w[i]), 16'(m_act[i]));
            check(i, "select", 16'(sel_w[i]), 16'(e_sel));
            check(i, "ack", 16'(ack_w[i]), 16'(e_ack));
            check(i, "noe", 16'(noe_w[i]), 16'(!(e_stb && !m_wr[i])));
            check(i, "nwe", 16'(nwe_w[i]), 16'(!(e_stb && m_wr[i])));
            check(i, "drive", 16'(drv_w[i]), 16'(e_sel && m_wr[i]));
            check(i, "address", 16'(addr_w[i]), 16'(m_addr[i]));
            check(i, "rdata", 16'(rdata_w[i]), 16'(m_rd[i]));
            if (e_sel && m_wr[i]) check(i, "bus", 16'(bus_w[i]), 16'(m_wd[i]));
        end
    end

    // Per-cycle activity masks; bit c holds cycle c after the acceptance edge.
    logic [1:0][15:0]      w_sel, w_noe, w_nwe, w_ack, w_drv;
    logic [1:0][15:0][7:0] w_rd;

    task automatic window(input int n, input int drop_at);
        w_sel = '0; w_noe = '0; w_nwe = '0; w_ack = '0; w_drv = '0; w_rd = '0;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (c == drop_at) req = 1'b0;
            for (int i = 0; i < 2; i++) begin
                w_sel[i][c] = sel_w[i];
                w_noe[i][c] = ~noe_w[i];
                w_nwe[i][c] = ~nwe_w[i];
                w_ack[i][c] = ack_w[i];
                w_drv[i][c] = drv_w[i];
                w_rd[i][c]  = rdata_w[i];
            end
        end
    endtask

    task automatic start(input logic wr, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        req = 1'b1; write = wr; address = a; wdata = d;
        @(posedge clk);
        #1 req = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy_w != 2'b00) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(0, "idle_timeout", 16'(n >= 50), 16'd0);
    endtask

    initial begin
        #2;
        check(0, "rst_noe", 16'(noe_w[0]), 16'd1);
        check(0, "rst_nwe", 16'(nwe_w[0]), 16'd1);
        check(0, "rst_addr", 16'(addr_w[0]), 16'd0);
        check(0, "rst_busy", 16'(busy_w[0]), 16'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Write 5A to 00.
        start(1'b1, 8'h00, 8'h5A);
        window(8, 0);
        check(0, "wr_nwe", w_nwe[0], 16'h000C);
        check(0, "wr_sel", w_sel[0], 16'h001E);
        check(0, "wr_drive", w_drv[0], 16'h001E);
        check(0, "wr_ack", w_ack[0], 16'h0020);
        check(1, "wr_nwe", w_nwe[1], 16'h0006);
        check(1, "wr_ack", w_ack[1], 16'h0008);
        wait_idle();

        // Read 00 with C3 on the bus.
        bus_in = 8'hC3;
        start(1'b0, 8'h00, 8'h00);
        window(8, 0);
        check(0, "rd_noe", w_noe[0], 16'h000C);
        check(0, "rd_drive", w_drv[0], 16'h0000);
        check(0, "rd_ack", w_ack[0], 16'h0020);
        check(0, "rd_data_c3", 16'(w_rd[0][3]), 16'h0000);
        check(0, "rd_data_c4", 16'(w_rd[0][4]), 16'h00C3);
        check(1, "rd_noe", w_noe[1], 16'h0006);
        check(1, "rd_data_c3", 16'(w_rd[1][3]), 16'h00C3);
        wait_idle();

        // Slow region read 80, then 7F on the fast side of the boundary.
        bus_in = 8'h3C;
        start(1'b0, 8'h80, 8'h00);
        window(10, 0);
        check(0, "slow_noe", w_noe[0], 16'h003C);
        check(0, "slow_ack", w_ack[0], 16'h0080);
        check(1, "slow_noe", w_noe[1], 16'h001E);
        check(1, "slow_ack", w_ack[1], 16'h0020);
        wait_idle();
        bus_in = 8'h7E;
        start(1'b0, 8'h7F, 8'h00);
        window(8, 0);
        check(0, "fast_noe", w_noe[0], 16'h000C);
        check(0, "fast_ack", w_ack[0], 16'h0020);
        check(0, "fast_addr", 16'(addr_w[0]), 16'h007F);
        wait_idle();

        // Request held across two writes.
        @(negedge clk);
        req = 1'b1; write = 1'b1; address = 8'h10; wdata = 8'hA5;
        @(posedge clk);
        window(14, 7);
        check(0, "b2b_ack", w_ack[0], 16'h0820);
        check(0, "b2b_sel", w_sel[0], 16'h079E);
        check(1, "b2b_ack", w_ack[1], 16'h0088);
        wait_idle();

        // Reset in the second strobe cycle of a write.
        start(1'b1, 8'h22, 8'h11);
        repeat (3) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check(0, "arst_nwe", 16'(nwe_w[0]), 16'd1);
        check(0, "arst_sel", 16'(sel_w[0]), 16'd0);
        check(0, "arst_busy", 16'(busy_w[0]), 16'd0);
        check(0, "arst_ack", 16'(ack_w[0]), 16'd0);
        check(0, "arst_rdata", 16'(rdata_w[0]), 16'd0);
        check(1, "arst_ack", 16'(ack_w[1]), 16'd0);
        @(negedge clk);
        // Request present in the very first cycle after release.
        resetn = 1'b1; req = 1'b1; write = 1'b0; address = 8'h05; bus_in = 8'h99;
        @(posedge clk);
        #1 req = 1'b0;
        window(8, 0);
        check(0, "post_rst_ack", w_ack[0], 16'h0020);
        check(0, "post_rst_rd", 16'(w_rd[0][4]), 16'h0099);
        check(1, "post_rst_ack", w_ack[1], 16'h0008);
        wait_idle();

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
